// File: rtl/icache_resp_pkg.sv
// Shared definitions for the instruction-cache responder.
// Holds the responder state encoding, default geometry and the kseg1 segment code.
// The kseg1 code is only used when ICACHE_UNCACHED_EN is defined.
package icache_resp_pkg;

    localparam int ICACHE_INDEX_W = 6;
    localparam int ICACHE_OFFS_W  = 3;

    // Top three pc bits that mark the uncached kseg1 window
    localparam logic [2:0] KSEG1_SEG = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_UDONE = 2'd3
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped storage for the instruction cache: valid bits, tags and line data.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears valid bits only)
//   rd_index/rd_offset  combinational read address; rd_valid/rd_tag/rd_data read data
//   wr_en/wr_index/wr_offset/wr_data   single-word write of a refill beat
//   fill_en/fill_tag    install tag and set valid for line wr_index
//   inv_all             clear every valid bit; wins over fill_en in the same cycle
module icache_array
    import icache_resp_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int OFFS_W  = ICACHE_OFFS_W,
    parameter int TAG_W   = 32 - INDEX_W - OFFS_W - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [OFFS_W-1:0]  rd_offset,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [OFFS_W-1:0]  wr_offset,
    input  logic [31:0]        wr_data,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic               inv_all
);
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFS_W;

    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [31:0]      data_r [LINES][WORDS];

    // Valid bits: invalidate-all takes priority so a line filled alongside it ends up invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (inv_all) begin
            valid_r <= '0;
        end else if (fill_en) begin
            valid_r[wr_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage carry no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[wr_index] <= fill_tag;
        end
        if (wr_en) begin
            data_r[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_data  = data_r[rd_index][rd_offset];

endmodule

// File: rtl/icache_resp_chk.sv
// Protocol checker for the refill port of icache_resp (simulation only).
// Ports:
//   clk, rst   clock, active-low reset (checks disabled while low)
//   line_beat  a cached refill beat is accepted this cycle
//   cnt_last   the beat counter already points at the last word of the line
//   rlast      memory marks this beat as final
module icache_resp_chk (
    input logic clk,
    input logic rst,
    input logic line_beat,
    input logic cnt_last,
    input logic rlast
);
    // A line refill must end on its last word; a further beat would wrap the counter
    property p_no_beat_overflow;
        @(posedge clk) disable iff (!rst) (line_beat && cnt_last) |-> rlast;
    endproperty

    a_no_beat_overflow: assert property (p_no_beat_overflow);

endmodule

// File: rtl/icache_resp.sv
// Instruction-cache responder: direct-mapped cache looked up combinationally on the
// registered fetch pc, with a single outstanding line refill over a burst memory port.
// A miss raises stallreq until the line is installed; the following cycle hits.
// Optional feature: ICACHE_UNCACHED_EN makes kseg1 fetches (pc[31:29] == 3'b101)
// bypass the arrays as single-word reads that are never allocated.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   icache_pc, icache_ce           fetch address and request valid
//   flush                          pipeline redirect; an active refill is never aborted
//   inv_all                        one-cycle pulse, invalidate every line
//   icache_inst, icache_valid      returned instruction word and its valid
//   stallreq                       freeze request to the stall controller
//   mem_req/mem_addr/mem_len/mem_gnt             refill request handshake
//   mem_rvalid/mem_rdata/mem_rlast               refill read beats
module icache_resp
    import icache_resp_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int OFFS_W  = ICACHE_OFFS_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     icache_pc,
    input  logic            icache_ce,
    input  logic            flush,
    input  logic            inv_all,
    output logic [31:0]     icache_inst,
    output logic            icache_valid,
    output logic            stallreq,
    output logic            mem_req,
    output logic [31:0]     mem_addr,
    output logic [OFFS_W:0] mem_len,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_rlast
);
    localparam int TAG_W   = 32 - INDEX_W - OFFS_W - 2;
    localparam int TAG_LSB = INDEX_W + OFFS_W + 2;
    localparam logic [OFFS_W:0]   LEN_LINE = {1'b0, {OFFS_W{1'b1}}};
    localparam logic [OFFS_W:0]   LEN_WORD = '0;
    localparam logic [OFFS_W-1:0] CNT_ONE  = {{(OFFS_W-1){1'b0}}, 1'b1};
    localparam logic [OFFS_W-1:0] CNT_MAX  = '1;

    function automatic logic [31:0] line_base(input logic [31:0] a);
        line_base = {a[31:OFFS_W+2], {(OFFS_W+2){1'b0}}};
    endfunction

    // Address split of the fetch pc
    logic [TAG_W-1:0]   pc_tag_s;
    logic [INDEX_W-1:0] pc_index_s;
    logic [OFFS_W-1:0]  pc_offs_s;
    assign pc_tag_s   = icache_pc[31:TAG_LSB];
    assign pc_index_s = icache_pc[TAG_LSB-1:OFFS_W+2];
    assign pc_offs_s  = icache_pc[OFFS_W+1:2];

    logic uncached_s;
`ifdef ICACHE_UNCACHED_EN
    assign uncached_s = (icache_pc[31:29] == KSEG1_SEG);
`else
    assign uncached_s = 1'b0;
`endif

    // Redirects need no action here: the pipeline register drops ce and a stall is never cut short
    logic unused_s;
    assign unused_s = ^{flush, icache_pc[1:0]};

    icache_state_e     state_r, state_s;
    logic [31:0]       miss_addr_r, miss_addr_s;
    logic              uc_r, uc_s;
    logic [OFFS_W-1:0] cnt_r, cnt_s;
    logic              inv_pend_r, inv_pend_s;
    logic [31:0]       uc_word_r, uc_word_s;
    logic              mem_req_r, mem_req_s;
    logic [OFFS_W:0]   mem_len_r, mem_len_s;

    logic              arr_valid_s;
    logic [TAG_W-1:0]  arr_tag_s;
    logic [31:0]       arr_data_s;
    logic              arr_wr_en_s, arr_fill_en_s, arr_inv_s;
    logic              hit_s, miss_s;
    logic              icache_valid_s, stallreq_s;
    logic [31:0]       icache_inst_s;

    icache_array #(
        .INDEX_W (INDEX_W),
        .OFFS_W  (OFFS_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (pc_index_s),
        .rd_offset (pc_offs_s),
        .rd_valid  (arr_valid_s),
        .rd_tag    (arr_tag_s),
        .rd_data   (arr_data_s),
        .wr_en     (arr_wr_en_s),
        .wr_index  (miss_addr_r[TAG_LSB-1:OFFS_W+2]),
        .wr_offset (cnt_r),
        .wr_data   (mem_rdata),
        .fill_en   (arr_fill_en_s),
        .fill_tag  (miss_addr_r[31:TAG_LSB]),
        .inv_all   (arr_inv_s)
    );

    icache_resp_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .line_beat ((state_r == ST_FILL) && mem_rvalid && !uc_r),
        .cnt_last  (cnt_r == CNT_MAX),
        .rlast     (mem_rlast)
    );

    assign hit_s  = icache_ce & arr_valid_s & (arr_tag_s == pc_tag_s) & ~uncached_s;
    assign miss_s = icache_ce & ~hit_s;

    // State and refill bookkeeping registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            miss_addr_r <= 32'h0;
            uc_r        <= 1'b0;
            cnt_r       <= '0;
            inv_pend_r  <= 1'b0;
            uc_word_r   <= 32'h0;
            mem_req_r   <= 1'b0;
            mem_len_r   <= '0;
        end else begin
            state_r     <= state_s;
            miss_addr_r <= miss_addr_s;
            uc_r        <= uc_s;
            cnt_r       <= cnt_s;
            inv_pend_r  <= inv_pend_s;
            uc_word_r   <= uc_word_s;
            mem_req_r   <= mem_req_s;
            mem_len_r   <= mem_len_s;
        end
    end

    // Next-state, refill sequencing and fetch-side outputs
    always_comb begin
        state_s        = state_r;
        miss_addr_s    = miss_addr_r;
        uc_s           = uc_r;
        cnt_s          = cnt_r;
        inv_pend_s     = inv_pend_r;
        uc_word_s      = uc_word_r;
        mem_req_s      = mem_req_r;
        mem_len_s      = mem_len_r;
        arr_wr_en_s    = 1'b0;
        arr_fill_en_s  = 1'b0;
        arr_inv_s      = 1'b0;
        icache_valid_s = 1'b0;
        icache_inst_s  = 32'h0;
        stallreq_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                icache_valid_s = hit_s;
                icache_inst_s  = hit_s ? arr_data_s : 32'h0;
                stallreq_s     = miss_s;
                arr_inv_s      = inv_all;
                if (miss_s) begin
                    state_s   = ST_REQ;
                    mem_req_s = 1'b1;
                    uc_s      = uncached_s;
                    if (uncached_s) begin
                        miss_addr_s = {icache_pc[31:2], 2'b00};
                        mem_len_s   = LEN_WORD;
                    end else begin
                        miss_addr_s = line_base(icache_pc);
                        mem_len_s   = LEN_LINE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stallreq_s = 1'b1;
                inv_pend_s = inv_pend_r | inv_all;
                if (mem_gnt) begin
                    mem_req_s = 1'b0;
                    cnt_s     = '0;
                    state_s   = ST_FILL;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_FILL: begin
                stallreq_s = 1'b1;
                inv_pend_s = inv_pend_r | inv_all;
                if (mem_rvalid) begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (uc_r) begin
                        // Single uncached beat: hand it out from UDONE, nothing is allocated
                        uc_word_s  = mem_rdata;
                        arr_inv_s  = inv_pend_r | inv_all;
                        inv_pend_s = 1'b0;
                        state_s    = ST_UDONE;
                    end else if (mem_rlast) begin
                        // A deferred invalidate also drops the line installed on this edge
                        arr_wr_en_s   = 1'b1;
                        arr_fill_en_s = 1'b1;
                        arr_inv_s     = inv_pend_r | inv_all;
                        inv_pend_s    = 1'b0;
                        state_s       = ST_IDLE;
                    end else begin
                        arr_wr_en_s = 1'b1;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_UDONE: begin
                icache_valid_s = 1'b1;
                icache_inst_s  = uc_word_r;
                arr_inv_s      = inv_all;
                state_s        = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign icache_valid = icache_valid_s;
    assign icache_inst  = icache_inst_s;
    assign stallreq     = stallreq_s & rst;
    assign mem_req      = mem_req_r;
    assign mem_addr     = miss_addr_r;
    assign mem_len      = mem_len_r;

endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp with a line-level reference model and per-cycle compare.
module tb_icache_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] icache_pc = 32'h0;
    logic        icache_ce = 1'b0;
    logic        flush = 1'b0;
    logic        inv_all = 1'b0;
    logic [31:0] icache_inst;
    logic        icache_valid;
    logic        stallreq;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_len;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rlast = 1'b0;

    always #5 clk = ~clk;

    icache_resp dut (
        .clk          (clk),
        .rst          (rst),
        .icache_pc    (icache_pc),
        .icache_ce    (icache_ce),
        .flush        (flush),
        .inv_all      (inv_all),
        .icache_inst  (icache_inst),
        .icache_valid (icache_valid),
        .stallreq     (stallreq),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_len      (mem_len),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_rlast    (mem_rlast)
    );

`ifdef ICACHE_UNCACHED_EN
    localparam logic [31:0] BASE = 32'h9FC0_0000;
`else
    localparam logic [31:0] BASE = 32'hBFC0_0000;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing memory contents: line words are 0x1000 + word number within a 4 KB page
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hA000_0100) return 32'hDEAD_BEEF;
        return 32'h1000 + {22'b0, a[11:2]};
    endfunction

    // ---------------- reference model (line granularity) ----------------
    logic        m_vld  [64];
    logic [31:0] m_line [64];
    logic [31:0] m_word [64][8];
    logic        m_busy, m_granted, m_uc, m_udone, m_invp;
    logic [31:0] m_miss, m_uword;
    int          m_beats;

    function automatic logic [31:0] lbase(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[10:5]);
    endfunction

    function automatic logic is_uc(input logic [31:0] a);
`ifdef ICACHE_UNCACHED_EN
        return a[31:29] == 3'b101;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic model_hit();
        return icache_ce && !is_uc(icache_pc) && m_vld[idx_of(icache_pc)]
               && (m_line[idx_of(icache_pc)] == lbase(icache_pc));
    endfunction

    function automatic logic exp_valid();
        return m_udone || (!m_busy && model_hit());
    endfunction

    function automatic logic [31:0] exp_inst();
        if (m_udone) return m_uword;
        if (!m_busy && model_hit()) return m_word[idx_of(icache_pc)][int'(icache_pc[4:2])];
        return 32'h0;
    endfunction

    function automatic logic exp_stall();
        if (m_udone) return 1'b0;
        if (m_busy) return 1'b1;
        return icache_ce && !model_hit();
    endfunction

    // Model update on each clock edge from the inputs seen at that edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) m_vld[i] <= 1'b0;
            m_busy <= 1'b0; m_granted <= 1'b0; m_uc <= 1'b0; m_udone <= 1'b0;
            m_invp <= 1'b0; m_miss <= 32'h0; m_uword <= 32'h0; m_beats <= 0;
        end else if (m_udone) begin
            m_udone <= 1'b0;
            if (inv_all) for (int i = 0; i < 64; i++) m_vld[i] <= 1'b0;
        end else if (!m_busy) begin
            if (inv_all) for (int i = 0; i < 64; i++) m_vld[i] <= 1'b0;
            if (icache_ce && !model_hit()) begin
                m_busy    <= 1'b1;
                m_granted <= 1'b0;
                m_uc      <= is_uc(icache_pc);
                m_miss    <= is_uc(icache_pc) ? icache_pc : lbase(icache_pc);
                m_beats   <= 0;
                m_invp    <= 1'b0;
            end
        end else begin
            if (inv_all) m_invp <= 1'b1;
            if (!m_granted) begin
                if (mem_gnt) m_granted <= 1'b1;
            end else if (mem_rvalid) begin
                if (m_uc) begin
                    m_uword <= mem_rdata;
                    m_busy  <= 1'b0;
                    m_udone <= 1'b1;
                    if (m_invp || inv_all) for (int i = 0; i < 64; i++) m_vld[i] <= 1'b0;
                end else begin
                    m_word[idx_of(m_miss)][m_beats] <= mem_rdata;
                    m_beats <= m_beats + 1;
                    if (mem_rlast) begin
                        m_line[idx_of(m_miss)] <= m_miss;
                        m_vld[idx_of(m_miss)]  <= 1'b1;
                        m_busy <= 1'b0;
                        if (m_invp || inv_all) for (int i = 0; i < 64; i++) m_vld[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (rst) begin
            check("valid",    32'(icache_valid), 32'(exp_valid()));
            check("inst",     icache_inst,       exp_inst());
            check("stallreq", 32'(stallreq),     32'(exp_stall()));
            check("mem_req",  32'(mem_req),      32'(m_busy && !m_granted));
            if (m_busy && !m_granted) begin
                check("mem_addr", mem_addr,     m_miss);
                check("mem_len",  32'(mem_len), m_uc ? 32'd0 : 32'd7);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [31:0] base, input int nbeats, input int gnt_wait,
                          input int gap_after, input int flush_beat, input int inv_beat);
        int k;
        k = 0;
        while (!mem_req && k < 20) begin
            tick();
            k++;
        end
        check("mem_req_seen", 32'(mem_req), 32'd1);
        repeat (gnt_wait) tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(base + 32'(4 * b));
            mem_rlast  = (b == nbeats - 1);
            flush      = (b == flush_beat);
            inv_all    = (b == inv_beat);
            tick();
            mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = 32'h0;
            flush = 1'b0; inv_all = 1'b0;
            if (b == gap_after) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(icache_valid), 32'd0);
        check("rst_inst",  icache_inst,       32'd0);
        check("rst_stall", 32'(stallreq),     32'd0);
        check("rst_req",   32'(mem_req),      32'd0);
        check("rst_addr",  mem_addr,          32'd0);
        check("rst_len",   32'(mem_len),      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Cold miss, line refill with grant wait and a gap between beats
        icache_pc = BASE; icache_ce = 1'b1;
        @(negedge clk);
        check("cold_stall", 32'(stallreq),     32'd1);
        check("cold_valid", 32'(icache_valid), 32'd0);
        tick();
        check("cold_req",  32'(mem_req),  32'd1);
        check("cold_addr", mem_addr,      BASE);
        check("cold_len",  32'(mem_len),  32'd7);
        refill(BASE, 8, 2, 3, -1, -1);
        @(negedge clk);
        check("cold_hit_valid", 32'(icache_valid), 32'd1);
        check("cold_hit_inst",  icache_inst,       32'h1000);
        check("cold_hit_stall", 32'(stallreq),     32'd0);
        tick();

        // Sequential hits through the line
        for (int i = 1; i < 8; i++) begin
            icache_pc = BASE + 32'(4 * i);
            @(negedge clk);
            check("seq_inst",  icache_inst,   32'h1000 + 32'(i));
            check("seq_stall", 32'(stallreq), 32'd0);
            check("seq_req",   32'(mem_req),  32'd0);
            tick();
        end

        // Conflict on the same index with a different tag
        icache_pc = BASE + 32'h800;
        @(negedge clk);
        check("conf_stall", 32'(stallreq), 32'd1);
        refill(BASE + 32'h800, 8, 0, -1, -1, -1);
        @(negedge clk);
        check("conf_inst", icache_inst, 32'h1200);
        tick();
        icache_pc = BASE;
        @(negedge clk);
        check("conf_refetch_miss", 32'(stallreq), 32'd1);
        refill(BASE, 8, 1, -1, -1, -1);
        @(negedge clk);
        check("conf_refetch_inst", icache_inst, 32'h1000);
        tick();

        // Flush during beat 3 does not abort the refill
        icache_pc = 32'h0000_0020;
        refill(32'h0000_0020, 8, 1, -1, 3, -1);
        @(negedge clk);
        check("flush_line_valid", 32'(icache_valid), 32'd1);
        check("flush_line_inst",  icache_inst,       32'h1008);
        tick();
        icache_pc = 32'h0000_0024;
        @(negedge clk);
        check("flush_redirect_inst", icache_inst, 32'h1009);
        tick();

        // inv_all during FILL: the just-filled line is invalid
        icache_pc = 32'h0000_0040;
        refill(32'h0000_0040, 8, 0, -1, -1, 4);
        @(negedge clk);
        check("inv_fill_refetch_miss", 32'(stallreq), 32'd1);
        refill(32'h0000_0040, 8, 0, -1, -1, -1);
        @(negedge clk);
        check("inv_fill_refill_inst", icache_inst, 32'h1010);
        tick();

        // inv_all in IDLE
        icache_ce = 1'b0; inv_all = 1'b1;
        tick();
        inv_all = 1'b0; icache_ce = 1'b1;
        @(negedge clk);
        check("inv_idle_miss", 32'(stallreq), 32'd1);
        refill(32'h0000_0040, 8, 0, -1, -1, -1);
        tick();

        // inv_all together with a miss detect
        icache_pc = 32'h0000_0060; inv_all = 1'b1;
        @(negedge clk);
        check("inv_simul_stall", 32'(stallreq), 32'd1);
        tick();
        inv_all = 1'b0;
        check("inv_simul_req", 32'(mem_req), 32'd1);
        refill(32'h0000_0060, 8, 0, -1, -1, -1);
        @(negedge clk);
        check("inv_simul_inst", icache_inst, 32'h1018);
        tick();
        icache_pc = 32'h0000_0040;
        @(negedge clk);
        check("inv_simul_cleared", 32'(stallreq), 32'd1);
        refill(32'h0000_0040, 8, 0, -1, -1, -1);
        tick();

        // No request
        icache_ce = 1'b0;
        @(negedge clk);
        check("ce0_valid", 32'(icache_valid), 32'd0);
        check("ce0_stall", 32'(stallreq),     32'd0);
        tick();

`ifdef ICACHE_UNCACHED_EN
        // Uncached kseg1 fetch: single beat, one valid cycle, never allocated
        icache_pc = 32'hA000_0100; icache_ce = 1'b1;
        @(negedge clk);
        check("uc_stall", 32'(stallreq), 32'd1);
        tick();
        check("uc_addr", mem_addr,     32'hA000_0100);
        check("uc_len",  32'(mem_len), 32'd0);
        refill(32'hA000_0100, 1, 0, -1, -1, -1);
        @(negedge clk);
        check("uc_valid", 32'(icache_valid), 32'd1);
        check("uc_inst",  icache_inst,       32'hDEAD_BEEF);
        check("uc_nostall", 32'(stallreq),   32'd0);
        tick();
        @(negedge clk);
        check("uc_repeat_miss", 32'(stallreq), 32'd1);
        refill(32'hA000_0100, 1, 1, -1, -1, -1);
        @(negedge clk);
        check("uc_repeat_inst", icache_inst, 32'hDEAD_BEEF);
        tick();
        icache_ce = 1'b0;
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_resp.md
Name: icache_resp

Overview:
- Responder end of the fetch interface driven by the PC→icache pipeline register. Consumes registered icache_pc/icache_ce and returns the instruction word.
- Direct-mapped instruction cache with single-outstanding line refill from a simple burst memory port.
- Raises stallreq on a miss so the stall controller freezes the PC stage and the pipeline register until the line is installed.

Parameters:
- INDEX_W, 6, line index bits (64 lines).
- OFFS_W, 3, word-offset bits (8 words/line, 32 B).
- TAG_W, 32-INDEX_W-OFFS_W-2, tag width; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- icache_pc  in  32  fetch address from the pipeline register, word aligned.
- icache_ce  in  1  fetch request valid.
- flush  in  1  pipeline flush (exception/branch redirect).
- inv_all  in  1  invalidate all lines (fence.i-style), one-cycle pulse.
- icache_inst  out  32  instruction word.
- icache_valid  out  1  icache_inst valid this cycle.
- stallreq  out  1  stall request to the stall controller.
- mem_req  out  1  refill request, held until mem_gnt.
- mem_addr  out  32  refill base address; line aligned, or word address when uncached.
- mem_len  out  OFFS_W+1  beats-1 (7 for a line, 0 uncached).
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  32  read beat data.
- mem_rlast  in  1  final beat.

Behaviour:
- Address split: tag = pc[31:INDEX_W+OFFS_W+2], index = pc[INDEX_W+OFFS_W+1:OFFS_W+2], offset = pc[OFFS_W+1:2].
- Storage is flop arrays: valid[2^INDEX_W], tag[2^INDEX_W], data[2^INDEX_W][2^OFFS_W].
- Reset (rst low, async):
  - all valid bits = 0; FSM = IDLE.
  - mem_req = 0, mem_addr = 0, mem_len = 0.
  - icache_inst = 0, icache_valid = 0, stallreq = 0.
  - Tag and data arrays are not reset.
- hit = icache_ce & valid[index] & (tag[index] == tag).
- Lookup is combinational on the held icache_pc. A hit in IDLE gives icache_valid = 1 and icache_inst = data[index][offset] in the same cycle, i.e. zero added latency. Otherwise icache_inst = 0.
- stallreq = (icache_ce & ~hit & state == IDLE) | (state != IDLE).
- FSM:
  - IDLE: on icache_ce & ~hit, latch the line-aligned pc into miss_addr and go to REQ.
  - REQ: mem_req = 1, mem_addr = miss_addr, mem_len = 7. On mem_gnt, clear beat counter and go to FILL. mem_req and mem_addr stay stable until mem_gnt.
  - FILL: each mem_rvalid writes data[miss_index][cnt] and increments a 3-bit cnt. On mem_rvalid & mem_rlast, set tag and valid for the line and go to IDLE. The next cycle's lookup hits and stallreq drops.
- Miss penalty: 1 (detect) + grant wait + 8 beats + 1 (re-lookup).
- Beat overflow: a beat arriving with cnt == 7 but without mem_rlast is a protocol error. cnt wraps, and the sim-only assertion fires.
- Flush:
  - In IDLE, no action beyond what the register upstream does (it drives ce = 0 next cycle).
  - In REQ/FILL, the transaction is never aborted. The refill completes and the line is installed, and stallreq stays 1 until return to IDLE; the stall controller gives flush priority.
  - The post-flush address is looked up fresh.
- inv_all:
  - In IDLE, clears every valid bit next edge.
  - In REQ/FILL, it is recorded and applied on the cycle the refill completes, so the just-filled line is also invalid.
  - Simultaneous inv_all and miss detect in IDLE: invalidate and enter REQ in the same edge.
- icache_ce = 0: icache_valid = 0, no state change.

Optional Feature:
- Macro: ICACHE_UNCACHED_EN.
- With the macro defined: a pc with pc[31:29] == 3'b101 (kseg1) bypasses the arrays and is always treated as a miss.
  - REQ issues mem_addr = pc, mem_len = 0.
  - On the single beat, FSM goes to UDONE and the word is held in a register.
  - UDONE drives icache_valid = 1 with that word for one cycle, with stallreq = 0, then returns to IDLE. No allocation.
- Without the macro: kseg1 addresses are cached like any other.

Decomposition:
- Shared defines header gains:
  - ICACHE state encoding (IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2, UDONE = 2'd3).
  - INDEX_W / OFFS_W defaults.
  - kseg1 segment constant 3'b101.
- One sub-module: icache_array (valid/tag/data storage with read port and line-write/invalidate ports). The FSM and memory port stay in icache_resp.

Test Plan:
- Cold miss at pc = 0xBFC0_0000 (macro off) → stallreq = 1 same cycle; mem_req with mem_addr = 0xBFC0_0000, mem_len = 7; after 8 beats of 0x1000+i, next cycle icache_valid = 1, icache_inst = 0x1000, stallreq = 0.
- Sequential pc 0xBFC0_0004…0xBFC0_001C after that fill → hit every cycle, inst 0x1001…0x1007, no mem_req.
- Conflict: pc 0xBFC0_0800 (same index, different tag) → miss and refill; re-fetch of 0xBFC0_0000 misses again.
- flush asserted during beat 3 of FILL → refill finishes at 8 beats, stallreq held high throughout, line valid afterwards.
- inv_all during FILL → after completion, a re-fetch of the same pc misses.
- Macro on: pc = 0xA000_0100 → mem_len = 0, one beat 0xDEAD_BEEF, then one cycle icache_valid = 1 / inst 0xDEAD_BEEF; a repeat fetch misses again.
